siso_6bit: RTL and testbench
============================

Name: siso_6bit

Overview:
- Serial-in serial-out shift register, 6 stages by default, single clock domain.
- Delays a 1-bit serial stream by exactly WIDTH clock cycles.
- Used as a fixed bit-delay line / serial pipeline element.
- Synchronous active-low clear and synchronous active-low preset force the whole chain to all-0 or all-1.

Parameters:
- WIDTH, 6, number of shift stages (serial delay in cycles); legal range 2..64.

Ports:
- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  synchronous, active-low reset; clears all stages to 0.
- preset  input  1  synchronous, active-low preset; sets all stages to 1.
- d  input  1  serial data in, sampled on rising clk edge.
- q  output  1  serial data out; registered value of the last stage.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset); the polarity and synchronicity of reset are fixed.
- State: WIDTH-bit register stage[WIDTH-1:0]; stage[0] is the input end, stage[WIDTH-1] drives q.
- Evaluation at each rising clk edge, in priority order:
  - reset==0: stage <= all 0.
  - else preset==0: stage <= all 1.
  - else shift: stage[0] <= d; stage[i] <= stage[i-1] for i = 1..WIDTH-1.
- reset has priority over preset. When both are low, the register clears.
- q = stage[WIDTH-1], driven directly from the flop with no combinational path from d.
- Reset value: q = 0 on the first edge with reset low. Preset value: q = 1 on the first edge with preset low.
- Latency: d sampled at edge N appears on q immediately after edge N+WIDTH-1. Default: d captured at edge 1 is visible on q after edge 6.
- Asynchronous reset/preset behaviour: none. Edges of reset or preset between clock edges have no effect.
- Releasing reset or preset: shifting resumes on the first edge with both high. The old contents (all 0 or all 1) drain out over the next WIDTH edges.
- Reset or preset mid-stream: in-flight bits are discarded immediately at that edge, with no partial shift.
- Before the first reset: contents are X. There is no internal initialisation, and the bench must reset first.

Optional Feature:
- Macro: SISO_PAR_OUT_EN.
- Defined: adds output port q_par [WIDTH-1:0] = stage[WIDTH-1:0]. This gives a parallel tap of all stages, with bit WIDTH-1 equal to q. It follows the same reset, preset, and shift behaviour.
- Undefined: the port does not exist. Behaviour on q is identical either way.

Decomposition:
- Package siso_pkg:
  - localparam SISO_DEFAULT_WIDTH = 6.
  - Enum/constants for stage control: CTL_CLEAR, CTL_SET, CTL_SHIFT.
- Sub-module siso_stage: one flop with sync active-low clear and set, plus a serial input.
- Top level generates WIDTH instances of siso_stage, chained stage[i-1] -> stage[i].
- Priority decode (reset over preset) lives once in the top level and is broadcast as the control code.

Test Plan:
- Reset: reset=0 for 2 edges with preset=1, d=1 -> q=0 after the first edge; with SISO_PAR_OUT_EN, q_par=6'b000000.
- Preset: reset=1, preset=0 for 1 edge -> q=1 (q_par=6'b111111); release preset, d=0 -> q stays 1 for 5 more edges, then 0 after the 6th edge.
- Latency: after reset, single 1 pulse on d at edge 1, then d=0 -> q=1 only in the cycle following edge 6; q=0 elsewhere.
- Stream: after reset, d toggles every 3 cycles (pattern 000111000111...) -> q reproduces the identical pattern delayed by exactly 6 cycles.
- Priority: reset=0 and preset=0 together while holding ones -> q=0 after the edge. Then reset=1 with preset=0 -> q=1 after the next edge.
- Mid-stream reset: load 6'b101101 by shifting, assert reset for one edge mid-drain -> q=0 at that edge, and the remaining bits never appear on q.

Source files
------------

// File: rtl/siso_pkg.sv
// Shared constants and stage-control codes for the siso shift-register family.
// The control code is decoded once at the top and broadcast to every stage.
package siso_pkg;

  localparam int SISO_DEFAULT_WIDTH = 6;
  localparam int SISO_MIN_WIDTH     = 2;
  localparam int SISO_MAX_WIDTH     = 64;

  typedef enum logic [1:0] {
    CTL_SHIFT = 2'b00,
    CTL_CLEAR = 2'b01,
    CTL_SET   = 2'b10
  } siso_ctl_e;

  // Clear wins over set when both active-low controls are asserted together.
  function automatic siso_ctl_e decode_ctl(input logic reset_n, input logic preset_n);
    siso_ctl_e ctl;
    if (!reset_n) begin
      ctl = CTL_CLEAR;
    end else if (!preset_n) begin
      ctl = CTL_SET;
    end else begin
      ctl = CTL_SHIFT;
    end
    return ctl;
  endfunction

endpackage

// File: rtl/siso_stage.sv
// One shift-register flop: synchronous clear, synchronous set, else load the
// serial input from the previous stage.
module siso_stage
  import siso_pkg::*;
(
  input  logic       clk,
  input  logic [1:0] ctl,
  input  logic       din,
  output logic       dout
);

  logic bit_reg;

  always_ff @(posedge clk) begin
    case (ctl)
      CTL_CLEAR: bit_reg <= 1'b0;
      CTL_SET:   bit_reg <= 1'b1;
      default:   bit_reg <= din;
    endcase
  end

  assign dout = bit_reg;

endmodule

// File: rtl/siso_6bit.sv
// Serial-in serial-out delay line of WIDTH stages with sync active-low clear/preset.
// Define SISO_PAR_OUT_EN to expose every stage on q_par.
module siso_6bit
  import siso_pkg::*;
#(
  parameter int WIDTH = SISO_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             d,
  output logic             q
`ifdef SISO_PAR_OUT_EN
  ,
  output logic [WIDTH-1:0] q_par
`endif
);

  siso_ctl_e        ctl_next;
  logic [1:0]       ctl_bus;
  logic [WIDTH-1:0] stage;
  logic [WIDTH-1:0] stage_in;

  always_comb begin
    ctl_next = decode_ctl(reset, preset);
  end

  assign ctl_bus = ctl_next;

  // stage[0] takes d; every later stage takes its predecessor.
  assign stage_in[0] = d;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign stage_in[gi] = stage[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      siso_stage u_stage (
        .clk  (clk),
        .ctl  (ctl_bus),
        .din  (stage_in[gi]),
        .dout (stage[gi])
      );
    end
  endgenerate

  assign q = stage[WIDTH-1];

`ifdef SISO_PAR_OUT_EN
  assign q_par = stage;
`endif

endmodule

// File: tb/tb_siso_6bit.sv
// Directed plus random check of siso_6bit against a queue-based delay-line model.
module tb_siso_6bit;

  localparam int W = 6;

  logic clk;
  logic reset;
  logic preset;
  logic d;
  logic q;
`ifdef SISO_PAR_OUT_EN
  logic [W-1:0] q_par;
`endif

  int errors = 0;
  int checks = 0;

  // hist holds the last W inputs since the last clear/set, oldest first.
  logic hist[$];

  siso_6bit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .preset (preset),
    .d      (d)
    ,.q     (q)
`ifdef SISO_PAR_OUT_EN
    ,.q_par (q_par)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic fill(input logic v);
    hist.delete();
    for (int i = 0; i < W; i++) hist.push_back(v);
  endtask

  task automatic check_q(input string tag, input logic exp_q);
    checks++;
    assert (q === exp_q) else begin
      errors++;
      $error("FAIL %s: q observed=%b expected=%b", tag, q, exp_q);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic p, input logic dv);
    logic exp_q;
    reset  = r;
    preset = p;
    d      = dv;
    @(posedge clk);
    if (!r) fill(1'b0);
    else if (!p) fill(1'b1);
    else begin
      hist.push_back(dv);
      void'(hist.pop_front());
    end
    #1;
    exp_q = hist[0];
    check_q(tag, exp_q);
`ifdef SISO_PAR_OUT_EN
    begin
      logic [W-1:0] exp_par;
      for (int i = 0; i < W; i++) exp_par[i] = hist[W-1-i];
      checks++;
      assert (q_par === exp_par) else begin
        errors++;
        $error("FAIL %s: q_par observed=%b expected=%b", tag, q_par, exp_par);
      end
    end
`endif
    $display("step %-8s reset=%b preset=%b d=%b q=%b", tag, r, p, dv, q);
  endtask

  initial begin
    int ones_seen;
    logic [5:0] pat;
    reset  = 1'b1;
    preset = 1'b1;
    d      = 1'b0;
    @(negedge clk);

    // Reset for two edges while d=1.
    step("reset", 1'b0, 1'b1, 1'b1);
    check_q("reset_const", 1'b0);
    step("reset", 1'b0, 1'b1, 1'b1);

    // Preset, then drain the ones with d=0.
    step("preset", 1'b1, 1'b0, 1'b0);
    check_q("preset_const", 1'b1);
    for (int i = 0; i < 5; i++) step("drain1", 1'b1, 1'b1, 1'b0);
    check_q("drain1_hold", 1'b1);
    step("drain1", 1'b1, 1'b1, 1'b0);
    check_q("drain1_end", 1'b0);

    // Single-pulse latency: visible only after the sixth edge.
    step("reset", 1'b0, 1'b1, 1'b0);
    ones_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      step("latency", 1'b1, 1'b1, (i == 1) ? 1'b1 : 1'b0);
      if (q === 1'b1) ones_seen++;
      if (i == W) check_q("latency_edge", 1'b1);
    end
    checks++;
    assert (ones_seen == 1) else begin
      errors++;
      $error("FAIL latency_count: ones observed=%0d expected=%0d", ones_seen, 1);
    end

    // 000111 stream.
    step("reset", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) step("stream", 1'b1, 1'b1, ((i / 3) % 2) == 1);

    // Priority: clear beats preset.
    step("fill1", 1'b1, 1'b0, 1'b0);
    step("both", 1'b0, 1'b0, 1'b1);
    check_q("prio_clear", 1'b0);
    step("preset", 1'b1, 1'b0, 1'b0);
    check_q("prio_set", 1'b1);

    // Mid-stream reset discards in-flight bits.
    step("reset", 1'b0, 1'b1, 1'b0);
    pat = 6'b101101;
    for (int i = 0; i < W; i++) step("load", 1'b1, 1'b1, pat[i]);
    for (int i = 0; i < 3; i++) step("drain2", 1'b1, 1'b1, 1'b0);
    step("midrst", 1'b0, 1'b1, 1'b0);
    check_q("midrst_const", 1'b0);
    for (int i = 0; i < W + 2; i++) begin
      step("after", 1'b1, 1'b1, 1'b0);
      check_q("after_const", 1'b0);
    end

    // Random traffic with occasional clear/preset pulses.
    for (int i = 0; i < 300; i++) begin
      step("random", ($urandom_range(15) != 0), ($urandom_range(15) != 0), 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
